// File: rtl/ff_pkg.sv
// Purpose: shared mode encoding and next-state function for the universal shift register.
// Latency: n/a (package of constants and a pure combinational function).
// Backpressure: n/a; no handshake, the register advances whenever it is enabled.
//
// Contents:
//   MODE_* : 3-bit operating mode constants
//   next_q : next register value for a given mode, computed on a 64-bit
//            zero-extended view of the register so one function serves every WIDTH
package ff_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASHR  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam int unsigned MAX_WIDTH = 64;

  // q and d must be zero above bit width-1. The result is masked back to
  // width bits, so the upper bits of the return value are always zero.
  function automatic logic [63:0] next_q(
    input logic [63:0] q,
    input logic [2:0]  mode,
    input logic [63:0] d,
    input logic        sin_l,
    input logic        sin_r,
    input int unsigned width
  );
    logic [63:0] r;
    logic [63:0] mask;
    logic        msb_bit;
    int unsigned msb;
    msb     = width - 1;
    // Read the live MSB without a variable part-select.
    msb_bit = |(q & (64'd1 << msb));
    case (mode)
      MODE_HOLD:  r = q;
      MODE_LOAD:  r = d;
      MODE_SHL:   r = {q[62:0], sin_r};
      MODE_SHR:   r = (q >> 1) | ({63'd0, sin_l} << msb);
      MODE_ROTL:  r = {q[62:0], msb_bit};
      MODE_ROTR:  r = (q >> 1) | ({63'd0, q[0]} << msb);
      MODE_ASHR:  r = (q >> 1) | ({63'd0, msb_bit} << msb);
      MODE_CLEAR: r = '0;
      // Unknown mode values fall back to hold.
      default:    r = q;
    endcase
    mask = (width >= MAX_WIDTH) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return r & mask;
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// Purpose: one bit of the universal shift register: mode mux plus flop with sync reset/set.
// Latency: one clock from inputs to q.
// Backpressure: none; en==0 holds the bit.
//
// Ports:
//   clk, reset (sync, active-low, highest priority), set (sync, active-low), en
//   mode                       : operating mode (ff_pkg::MODE_*)
//   d_bit                      : parallel load bit
//   shl_bit/shr_bit            : value this bit takes on a logical left/right shift
//   rotl_bit/rotr_bit/ashr_bit : value this bit takes on rotate/arithmetic shift
//   q                          : stored bit
module usr_bit_cell
  import ff_pkg::*;
#(
  parameter logic RST_BIT = 1'b0,
  parameter logic SET_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       d_bit,
  input  logic       shl_bit,
  input  logic       shr_bit,
  input  logic       rotl_bit,
  input  logic       rotr_bit,
  input  logic       ashr_bit,
  output logic       q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (!reset) begin
      q_d = RST_BIT;
    end else if (!set) begin
      q_d = SET_BIT;
    end else if (en) begin
      case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = d_bit;
        MODE_SHL:   q_d = shl_bit;
        MODE_SHR:   q_d = shr_bit;
        MODE_ROTL:  q_d = rotl_bit;
        MODE_ROTR:  q_d = rotr_bit;
        MODE_ASHR:  q_d = ashr_bit;
        MODE_CLEAR: q_d = 1'b0;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Purpose: WIDTH-bit universal shift register (hold/load/shift/rotate/arith-shift/clear) with flags.
// Latency: one clock from edge to new q, sout_l/sout_r, zero and parity; qbar is combinational.
// Backpressure: none; en==0 freezes register and all flags.
//
// Ports:
//   clk, reset (sync active-low, highest priority), set (sync active-low), en
//   mode[2:0] : ff_pkg::MODE_* operation select
//   d         : parallel load data
//   sin_l     : serial in at MSB on SHR;  sin_r : serial in at LSB on SHL
//   q, qbar   : register contents and complement
//   sout_l    : bit last shifted out of MSB (SHL/ROTL); sout_r : out of LSB (SHR/ROTR/ASHR)
//   zero      : q == 0;  parity : ^q   (both registered alongside q)
module univ_shift_reg
  import ff_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             parity
);

  logic [WIDTH-1:0] q_bits;

  // Neighbour values each bit takes for the shifting modes.
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] rotl_v;
  logic [WIDTH-1:0] rotr_v;
  logic [WIDTH-1:0] ashr_v;

  always_comb begin
    shl_v  = {q_bits[WIDTH-2:0], sin_r};
    shr_v  = {sin_l, q_bits[WIDTH-1:1]};
    rotl_v = {q_bits[WIDTH-2:0], q_bits[WIDTH-1]};
    rotr_v = {q_bits[0], q_bits[WIDTH-1:1]};
    ashr_v = {q_bits[WIDTH-1], q_bits[WIDTH-1:1]};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell #(
      .RST_BIT (RESET_VAL[i]),
      .SET_BIT (SET_VAL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .set      (set),
      .en       (en),
      .mode     (mode),
      .d_bit    (d[i]),
      .shl_bit  (shl_v[i]),
      .shr_bit  (shr_v[i]),
      .rotl_bit (rotl_v[i]),
      .rotr_bit (rotr_v[i]),
      .ashr_bit (ashr_v[i]),
      .q        (q_bits[i])
    );
  end

  // Flags are derived from the same next-state value the cells will load,
  // so zero/parity land on the same edge as q and never lag it.
  logic [63:0] q_ext;
  logic [63:0] d_ext;
  logic [63:0] nq_ext;

  always_comb begin
    q_ext             = '0;
    q_ext[WIDTH-1:0]  = q_bits;
    d_ext             = '0;
    d_ext[WIDTH-1:0]  = d;
    nq_ext            = next_q(q_ext, mode, d_ext, sin_l, sin_r, WIDTH);
  end

  logic sout_l_q, sout_l_d;
  logic sout_r_q, sout_r_d;
  logic zero_q,   zero_d;
  logic parity_q, parity_d;

  always_comb begin
    sout_l_d = sout_l_q;
    sout_r_d = sout_r_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    if (!reset) begin
      sout_l_d = 1'b0;
      sout_r_d = 1'b0;
      zero_d   = (RESET_VAL == '0);
      parity_d = ^RESET_VAL;
    end else if (!set) begin
      sout_l_d = 1'b0;
      sout_r_d = 1'b0;
      zero_d   = (SET_VAL == '0);
      parity_d = ^SET_VAL;
    end else if (en) begin
      zero_d   = (nq_ext == 64'd0);
      parity_d = ^nq_ext;
      case (mode)
        MODE_SHL, MODE_ROTL:            sout_l_d = q_bits[WIDTH-1];
        MODE_SHR, MODE_ROTR, MODE_ASHR: sout_r_d = q_bits[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    sout_l_q <= sout_l_d;
    sout_r_q <= sout_r_d;
    zero_q   <= zero_d;
    parity_q <= parity_d;
  end

  assign q      = q_bits;
  assign qbar   = ~q_bits;
  assign sout_l = sout_l_q;
  assign sout_r = sout_r_q;
  assign zero   = zero_q;
  assign parity = parity_q;

  // An unknown mode is treated as hold by the datapath; flag it in simulation.
  mode_known_a: assert property (@(posedge clk) (reset && set && en) |-> !$isunknown(mode));

endmodule
